traffic_uart_rx: RTL and testbench

//  Serial receiver for roadside traffic-signal frames, 8 data bits, LSB first, 16x oversampled.

---
 rtl/traffic_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/traffic_uart_rx.sv | 186 ++++++++++++++++++
 tb/tb_traffic_uart_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-signal serial link: colour codes, frame header,
// receiver FSM states and the frame-content check.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  localparam logic [5:0] FRAME_HDR = 6'b101010;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned TICK_W    = 4;
  localparam int unsigned BIT_IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Header matches and the colour field is one of the three defined codes.
  function automatic logic frame_ok(input logic [DATA_BITS-1:0] b);
    return (b[7:2] == FRAME_HDR) && (b[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock tick every CLK_HZ/(BAUD*OVERSAMPLE) clocks,
// realigned to zero by i_restart so sampling phase follows the start edge.
module uart_baud_tick #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_restart) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CW'(DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/traffic_uart_rx.sv
// Traffic-signal frame receiver: 8 data bits LSB first, 16x oversampled, decoded to a colour.
// Define UART_PARITY_EN to expect an even-parity bit between D7 and the stop bit.
module traffic_uart_rx
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 valid_uart_data,
  output logic [1:0]           uart_data_sig,
  output logic                 frame_err,
  output logic [DATA_BITS-1:0] rx_byte
);

  rx_state_e r_state, w_state_nxt;

  logic                 r_rx_meta, r_rx_sync, r_rx_prev;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_valid, r_err;
  logic [1:0]           r_colour;
  logic [DATA_BITS-1:0] r_rx_byte;

  logic w_tick, w_fall, w_mid, w_good;
  logic w_restart, w_shift_en, w_stop_smp;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;

  uart_baud_tick #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_tick (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // Mid-bit: half a bit into the start bit, a full bit for every later bit.
  assign w_mid = w_tick &&
                 (r_tick_cnt == ((r_state == ST_START) ? TICK_W'(7) : TICK_W'(15)));

`ifdef UART_PARITY_EN
  logic r_par_bit;
  logic w_par_smp;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_par_bit <= 1'b0;
    end else if (w_par_smp) begin
      r_par_bit <= r_rx_sync;
    end
  end

  assign w_good = r_rx_sync && frame_ok(r_shift) && (r_par_bit == ^r_shift);
`else
  assign w_good = r_rx_sync && frame_ok(r_shift);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_shift_en  = 1'b0;
    w_stop_smp  = 1'b0;
`ifdef UART_PARITY_EN
    w_par_smp   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_restart   = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_mid) begin
          w_state_nxt = r_rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_mid) begin
          w_shift_en = 1'b1;
          if (r_bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
      ST_PARITY: begin
        if (w_mid) begin
`ifdef UART_PARITY_EN
          w_par_smp   = 1'b1;
`endif
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_mid) begin
          w_stop_smp  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Oversample tick counter, bit index and LSB-first shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      if (w_restart || w_mid) begin
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      end
      if (w_restart) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
      end
      if (w_shift_en) begin
        r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
      end
    end
  end

  // Decode on the stop-bit sample; strobes last exactly one clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_colour  <= RED;
      r_rx_byte <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_stop_smp) begin
        r_rx_byte <= r_shift;
        if (w_good) begin
          r_colour <= r_shift[1:0];
          r_valid  <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign valid_uart_data = r_valid;
  assign frame_err       = r_err;
  assign uart_data_sig   = r_colour;
  assign rx_byte         = r_rx_byte;

endmodule

// File: tb/tb_traffic_uart_rx.sv
// Scoreboard bench for traffic_uart_rx at a reduced clock so a bit lasts 128 clocks.
// Honours UART_PARITY_EN the same way as the design.
module tb_traffic_uart_rx;

  localparam int unsigned CLK_HZ = 1_228_800;
  localparam int unsigned BAUD   = 9600;
  localparam int unsigned OS     = 16;
  localparam int unsigned DIV    = CLK_HZ / (BAUD * OS);
  localparam int unsigned BIT    = DIV * OS;
`ifdef UART_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam longint LAT_MID = longint'((NBITS - 1) * BIT + BIT / 2);

  typedef struct {
    logic       is_valid;
    logic [1:0] colour;
    logic [7:0] data;
    longint     start;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       valid_uart_data;
  logic [1:0] uart_data_sig;
  logic       frame_err;
  logic [7:0] rx_byte;

  exp_t       sb[$];
  logic [1:0] m_colour;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_valid = 0;
  longint     cyc = 0;

  traffic_uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .rx              (rx),
    .valid_uart_data (valid_uart_data),
    .uart_data_sig   (uart_data_sig),
    .frame_err       (frame_err),
    .rx_byte         (rx_byte)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(posedge clock);
    #1;
  endtask

  // Drive one frame and record what the receiver should report for it.
  task automatic send(input logic [7:0] b, input logic stop_v, input logic par_flip, input int gap);
    exp_t e;
    logic good;
    good = (b[7:2] == 6'b101010) && (b[1:0] != 2'b11) && stop_v && !par_flip;
    if (good) m_colour = b[1:0];
    e.is_valid = good;
    e.colour   = m_colour;
    e.data     = b;
    e.start    = cyc;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_v);
    for (int i = 0; i < gap; i++) drive_bit(1'b1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 4 * BIT && sb.size() != 0; i++) @(posedge clock);
    #1;
    check_eq(tag, sb.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_valid"}, valid_uart_data, 1'b0);
    check_eq({tag, "_ferr"}, frame_err, 1'b0);
    check_eq({tag, "_colour"}, uart_data_sig, 2'b00);
    check_eq({tag, "_rx_byte"}, rx_byte, 8'h00);
  endtask

  always @(negedge clock) begin
    if (!reset && (valid_uart_data || frame_err)) begin
      check_eq("excl", valid_uart_data & frame_err, 1'b0);
      if (valid_uart_data) n_valid++;
      if (sb.size() == 0) begin
        check_eq("spurious_strobe", {valid_uart_data, frame_err}, 2'b00);
      end else begin
        exp_t e;
        longint lat;
        e = sb.pop_front();
        lat = cyc - e.start;
        check_eq("valid", valid_uart_data, e.is_valid);
        check_eq("frame_err", frame_err, !e.is_valid);
        check_eq("colour", uart_data_sig, e.colour);
        check_eq("rx_byte", rx_byte, e.data);
        check_eq("latency_window", (lat >= LAT_MID) && (lat <= LAT_MID + 12), 1'b1);
      end
    end
  end

  initial begin
    #(80_000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    reset    = 1'b1;
    rx       = 1'b1;
    m_colour = 2'b00;
    repeat (5) @(posedge clock);
    #1;
    check_reset_vals("por");
    reset = 1'b0;
    repeat (2 * BIT) @(posedge clock);
    #1;

    // Single green frame
    send(8'hAA, 1'b1, 1'b0, 2);
    wait_drain("drain_aa");

    // Back-to-back red then yellow
    v0 = n_valid;
    send(8'hA8, 1'b1, 1'b0, 0);
    send(8'hA9, 1'b1, 1'b0, 2);
    wait_drain("drain_b2b");
    check_eq("b2b_valid_count", n_valid - v0, 2);

    // Bad colour field then bad header
    v0 = n_valid;
    send(8'hAB, 1'b1, 1'b0, 1);
    send(8'h2A, 1'b1, 1'b0, 2);
    wait_drain("drain_bad");
    check_eq("bad_no_valid", n_valid - v0, 0);
    check_eq("colour_held", uart_data_sig, 2'b01);
    check_eq("rx_byte_bad", rx_byte, 8'h2A);

    // Stop bit low, then a clean frame
    send(8'hAA, 1'b0, 1'b0, 3);
    send(8'hAA, 1'b1, 1'b0, 2);
    wait_drain("drain_stop");
    check_eq("after_stop_colour", uart_data_sig, 2'b10);

    // Short glitch (well under half a bit) must not start a frame
    rx = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    rx = 1'b1;
    repeat (3 * BIT) @(posedge clock);
    #1;
    send(8'hA9, 1'b1, 1'b0, 2);
    wait_drain("drain_glitch");
    check_eq("after_glitch_colour", uart_data_sig, 2'b01);

    // Line stuck low: a single error, then silence until it returns high
    begin
      exp_t e;
      e.is_valid = 1'b0;
      e.colour   = m_colour;
      e.data     = 8'h00;
      e.start    = cyc;
      sb.push_back(e);
    end
    rx = 1'b0;
    repeat (25 * BIT) @(posedge clock);
    #1;
    rx = 1'b1;
    repeat (2 * BIT) @(posedge clock);
    #1;
    check_eq("stuck_low_drain", sb.size(), 0);

    // Reset in the middle of data bit 4 discards the partial frame
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b1 : 1'b0);
    rx = 1'b0;
    repeat (BIT / 2) @(posedge clock);
    #1;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("mid_reset");
    reset    = 1'b0;
    m_colour = 2'b00;
    repeat (2 * BIT) @(posedge clock);
    #1;
    check_reset_vals("post_reset");
    send(8'hAA, 1'b1, 1'b0, 2);
    wait_drain("drain_reset");
    check_eq("after_reset_colour", uart_data_sig, 2'b10);

`ifdef UART_PARITY_EN
    // Wrong parity on an otherwise good frame
    send(8'hA8, 1'b1, 1'b1, 2);
    wait_drain("drain_parity");
    check_eq("parity_colour_held", uart_data_sig, 2'b10);
`endif

    check_eq("final_queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
